matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 The block SHALL have parameter AROWS, default 3, meaning rows of A and of C (>=1).
REQ-002 The block SHALL have parameter ACOLUMNS, default 3, meaning columns of A, rows of B and dot-product length (>=1).
REQ-003 The block SHALL have parameter BCOLUMNS, default 3, meaning columns of B and of C (>=1).
REQ-004 The block SHALL have parameter ADDR_W, default 16, meaning width of all address outputs.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clock and nreset.
REQ-006 The block SHALL have these ports (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- nreset  in  1  async active-low reset
- start  in  1  begin a multiply; sampled only in IDLE
- stall  in  1  freeze read issue in READ
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- rd_en  out  1  A/B operand read strobe
- a_addr  out  ADDR_W  A element address = i*ACOLUMNS+k
- b_addr  out  ADDR_W  B element address = k*BCOLUMNS+j
- acc_clr  out  1  clear the accumulator before adding this operand pair
- acc_en  out  1  accumulate the operand pair returned this cycle
- c_valid  out  1  C element ready for write
- c_ready  in  1  sink accepts C element
- c_addr  out  ADDR_W  C element address = i*BCOLUMNS+j

Function
REQ-007 The block SHALL implement an FSM with states IDLE, READ, DRAIN, WRITE, DONE; outputs rd_en, busy, c_valid and done SHALL be decoded from the state.
REQ-008 In IDLE, start=1 SHALL move the FSM to READ on the next edge with i=j=k=0; start SHALL be ignored in every other state.
REQ-009 In READ with stall=0, the block SHALL assert rd_en and present a_addr and b_addr for the current (i,j,k).
REQ-010 In READ with stall=1, the block SHALL deassert rd_en and hold i, j, k and the state.
REQ-011 In READ with stall=0: if k<ACOLUMNS-1, k SHALL increment; otherwise k SHALL hold and the FSM SHALL go to DRAIN.
REQ-012 Operand memory read latency SHALL be one cycle: acc_en SHALL be rd_en registered by one cycle, and acc_clr SHALL be (rd_en && k==0) registered by one cycle.
REQ-013 DRAIN SHALL last exactly one cycle and SHALL then go to WRITE.
REQ-014 In WRITE, the block SHALL hold c_valid=1 with a stable c_addr until a cycle with c_ready=1 (handshake).
REQ-015 On the WRITE handshake:
- if j<BCOLUMNS-1: j+1, k=0, go to READ;
- else if i<AROWS-1: i+1, j=0, k=0, go to READ;
- else go to DONE.
REQ-016 DONE SHALL assert done for exactly one cycle, return to IDLE, and clear i, j, k.
REQ-017 The block SHALL emit elements in row-major C order (i outer, j middle, k inner), with no index wrapping beyond parameter bounds.
REQ-018 With stall=0 and c_ready=1, each C element SHALL take ACOLUMNS+2 cycles, and done SHALL assert AROWS*BCOLUMNS*(ACOLUMNS+2)+1 cycles after the start-sampling edge.
REQ-019 Address arithmetic SHALL be unsigned, computed at ADDR_W bits and truncated to ADDR_W.
REQ-020 With ACOLUMNS=1, READ SHALL last one cycle per element, and that single read SHALL carry acc_clr.

Reset
REQ-021 When nreset=0, the block SHALL asynchronously enter IDLE with i=j=k=0 and all outputs 0 (addresses 0), including mid-operation.
REQ-022 After reset, the block SHALL accept a new start on the first edge at which nreset=1.

Verification
REQ-023 Bench SHALL cover: 2x2x2, stall=0, c_ready=1, start pulsed at cycle 0 -> c_addr sequence 0,1,2,3 on WRITE cycles 4,8,12,16; done at cycle 17 only.
REQ-024 Bench SHALL cover: 3x3x3 with stall=1 for 2 cycles at the second READ of element (0,0) -> rd_en low those cycles, a_addr holds 1, done delayed by exactly 2 cycles (46 to 48).
REQ-025 Bench SHALL cover: c_ready=0 for 5 cycles at the first WRITE -> c_valid held, c_addr=0 stable, next READ starts the cycle after c_ready=1.
REQ-026 Bench SHALL cover: acc_clr/acc_en check, 2x3x2 -> acc_en high for 3 consecutive cycles per element, acc_clr on the first of them only; b_addr for element (1,1) is 1,3,5.
REQ-027 Bench SHALL cover: nreset pulled low mid-READ of element (1,0) -> all outputs 0 immediately; start while busy ignored; fresh start after reset begins at element (0,0).
REQ-028 Bench SHALL cover: AROWS=ACOLUMNS=BCOLUMNS=1 -> READ 1 cycle with acc_clr asserted the next cycle, WRITE at cycle 3, done at cycle 4.

Source files
------------

// File: rtl/matmul_sequencer.sv
// Address/control sequencer for C = A x B with row-major C order.
// Issues operand reads, accumulator strobes and handshaked C writes.
module matmul_sequencer #(
  parameter int AROWS    = 3,
  parameter int ACOLUMNS = 3,
  parameter int BCOLUMNS = 3,
  parameter int ADDR_W   = 16
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              c_valid,
  input  logic              c_ready,
  output logic [ADDR_W-1:0] c_addr
);

  localparam int IW = $clog2(AROWS > 1 ? AROWS : 2);
  localparam int KW = $clog2(ACOLUMNS > 1 ? ACOLUMNS : 2);
  localparam int JW = $clog2(BCOLUMNS > 1 ? BCOLUMNS : 2);

  localparam logic [IW-1:0] I_LAST = IW'(AROWS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(ACOLUMNS - 1);
  localparam logic [JW-1:0] J_LAST = JW'(BCOLUMNS - 1);

  localparam logic [ADDR_W-1:0] AC_A = ADDR_W'(ACOLUMNS);
  localparam logic [ADDR_W-1:0] BC_A = ADDR_W'(BCOLUMNS);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic          acc_en_q, acc_en_d;
  logic          acc_clr_q, acc_clr_d;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      READ: begin
        if (!stall) begin
          if (k_q != K_LAST) k_d = k_q + KW'(1);
          else               state_d = DRAIN;
        end
      end
      DRAIN: state_d = WRITE;
      WRITE: begin
        if (c_ready) begin
          if (j_q != J_LAST) begin
            j_d     = j_q + JW'(1);
            k_d     = '0;
            state_d = READ;
          end else if (i_q != I_LAST) begin
            i_d     = i_q + IW'(1);
            j_d     = '0;
            k_d     = '0;
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_en   = (state_q == READ) && !stall;
  assign busy    = (state_q != IDLE);
  assign c_valid = (state_q == WRITE);
  assign done    = (state_q == DONE);

  // Operand data returns one cycle after the read strobe.
  assign acc_en_d  = rd_en;
  assign acc_clr_d = rd_en && (k_q == '0);
  assign acc_en    = acc_en_q;
  assign acc_clr   = acc_clr_q;

  assign a_addr = ADDR_W'(i_q) * AC_A + ADDR_W'(k_q);
  assign b_addr = ADDR_W'(k_q) * BC_A + ADDR_W'(j_q);
  assign c_addr = ADDR_W'(i_q) * BC_A + ADDR_W'(j_q);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      acc_en_q  <= acc_en_d;
      acc_clr_q <= acc_clr_d;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer over four shape configurations.
// Cycle 0 is the cycle in which start is presented.
module tb_matmul_sequencer;

  logic        clock;
  logic        nreset_s [4];
  logic        start_s  [4];
  logic        stall_s  [4];
  logic        crdy_s   [4];
  logic        busy_o   [4];
  logic        done_o   [4];
  logic        rd_o     [4];
  logic [15:0] a_o      [4];
  logic [15:0] b_o      [4];
  logic        clr_o    [4];
  logic        en_o     [4];
  logic        cv_o     [4];
  logic [15:0] ca_o     [4];

  int n_chk  = 0;
  int n_fail = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  matmul_sequencer #(.AROWS(2), .ACOLUMNS(2), .BCOLUMNS(2), .ADDR_W(16)) u0 (
    .clock(clock), .nreset(nreset_s[0]), .start(start_s[0]),
    .stall(stall_s[0]), .busy(busy_o[0]), .done(done_o[0]),
    .rd_en(rd_o[0]), .a_addr(a_o[0]), .b_addr(b_o[0]),
    .acc_clr(clr_o[0]), .acc_en(en_o[0]), .c_valid(cv_o[0]),
    .c_ready(crdy_s[0]), .c_addr(ca_o[0]));

  matmul_sequencer #(.AROWS(3), .ACOLUMNS(3), .BCOLUMNS(3), .ADDR_W(16)) u1 (
    .clock(clock), .nreset(nreset_s[1]), .start(start_s[1]),
    .stall(stall_s[1]), .busy(busy_o[1]), .done(done_o[1]),
    .rd_en(rd_o[1]), .a_addr(a_o[1]), .b_addr(b_o[1]),
    .acc_clr(clr_o[1]), .acc_en(en_o[1]), .c_valid(cv_o[1]),
    .c_ready(crdy_s[1]), .c_addr(ca_o[1]));

  matmul_sequencer #(.AROWS(2), .ACOLUMNS(3), .BCOLUMNS(2), .ADDR_W(16)) u2 (
    .clock(clock), .nreset(nreset_s[2]), .start(start_s[2]),
    .stall(stall_s[2]), .busy(busy_o[2]), .done(done_o[2]),
    .rd_en(rd_o[2]), .a_addr(a_o[2]), .b_addr(b_o[2]),
    .acc_clr(clr_o[2]), .acc_en(en_o[2]), .c_valid(cv_o[2]),
    .c_ready(crdy_s[2]), .c_addr(ca_o[2]));

  matmul_sequencer #(.AROWS(1), .ACOLUMNS(1), .BCOLUMNS(1), .ADDR_W(16)) u3 (
    .clock(clock), .nreset(nreset_s[3]), .start(start_s[3]),
    .stall(stall_s[3]), .busy(busy_o[3]), .done(done_o[3]),
    .rd_en(rd_o[3]), .a_addr(a_o[3]), .b_addr(b_o[3]),
    .acc_clr(clr_o[3]), .acc_en(en_o[3]), .c_valid(cv_o[3]),
    .c_ready(crdy_s[3]), .c_addr(ca_o[3]));

  typedef struct {
    bit start;
    bit rd;
    int a;
    int b;
    bit clr;
    bit en;
    bit cv;
    int ca;
    bit busy;
    bit done;
  } row_t;

  row_t tbl [19];

  int rec_rd [64];
  int rec_a  [64];
  int rec_b  [64];
  int rec_clr[64];
  int rec_en [64];
  int rec_cv [64];
  int rec_ca [64];
  int done_at;
  int done_n;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; records one sample per cycle.
  task automatic run(input int u, input int s_lo, input int s_hi,
                     input int r_lo, input int r_hi, input int ncyc);
    done_at = -1;
    done_n  = 0;
    for (int c = 0; c < ncyc; c++) begin
      start_s[u] = (c == 0);
      stall_s[u] = (c >= s_lo && c <= s_hi);
      crdy_s[u]  = !(c >= r_lo && c <= r_hi);
      #1;
      rec_rd[c]  = int'(rd_o[u]);
      rec_a[c]   = int'(a_o[u]);
      rec_b[c]   = int'(b_o[u]);
      rec_clr[c] = int'(clr_o[u]);
      rec_en[c]  = int'(en_o[u]);
      rec_cv[c]  = int'(cv_o[u]);
      rec_ca[c]  = int'(ca_o[u]);
      if (done_o[u]) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      @(posedge clock);
      @(negedge clock);
    end
    start_s[u] = 1'b0;
    stall_s[u] = 1'b0;
    crdy_s[u]  = 1'b1;
  endtask

  initial begin
    for (int u = 0; u < 4; u++) begin
      nreset_s[u] = 1'b0;
      start_s[u]  = 1'b0;
      stall_s[u]  = 1'b0;
      crdy_s[u]   = 1'b1;
    end

    // start, rd, a, b, clr, en, cv, ca, busy, done  (2x2x2)
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{0, 1, 1, 2, 1, 1, 0, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    tbl[5]  = '{0, 1, 0, 1, 0, 0, 0, 0, 1, 0};
    tbl[6]  = '{1, 1, 1, 3, 1, 1, 0, 0, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    tbl[9]  = '{0, 1, 2, 0, 0, 0, 0, 0, 1, 0};
    tbl[10] = '{0, 1, 3, 2, 1, 1, 0, 0, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 2, 1, 0};
    tbl[13] = '{0, 1, 2, 1, 0, 0, 0, 0, 1, 0};
    tbl[14] = '{0, 1, 3, 3, 1, 1, 0, 0, 1, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 1, 3, 1, 0};
    tbl[17] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy", int'(busy_o[0]), 0);
    chk("rst_cv", int'(cv_o[0]), 0);
    @(negedge clock);
    for (int u = 0; u < 4; u++) nreset_s[u] = 1'b1;
    @(negedge clock);

    // 2x2x2 cycle-by-cycle table, start also pulsed while busy / in DONE
    for (int c = 0; c < 19; c++) begin
      start_s[0] = tbl[c].start;
      #1;
      chk($sformatf("t%0d_rd", c), int'(rd_o[0]), int'(tbl[c].rd));
      chk($sformatf("t%0d_clr", c), int'(clr_o[0]), int'(tbl[c].clr));
      chk($sformatf("t%0d_en", c), int'(en_o[0]), int'(tbl[c].en));
      chk($sformatf("t%0d_cv", c), int'(cv_o[0]), int'(tbl[c].cv));
      chk($sformatf("t%0d_busy", c), int'(busy_o[0]), int'(tbl[c].busy));
      chk($sformatf("t%0d_done", c), int'(done_o[0]), int'(tbl[c].done));
      if (tbl[c].rd || !tbl[c].busy) begin
        chk($sformatf("t%0d_a", c), int'(a_o[0]), tbl[c].a);
        chk($sformatf("t%0d_b", c), int'(b_o[0]), tbl[c].b);
      end
      if (tbl[c].cv || !tbl[c].busy)
        chk($sformatf("t%0d_ca", c), int'(ca_o[0]), tbl[c].ca);
      @(posedge clock);
      @(negedge clock);
    end
    start_s[0] = 1'b0;

    // 3x3x3 with a 2-cycle stall on the second read of element (0,0)
    run(1, 2, 3, -1, -1, 60);
    chk("st_rd2", rec_rd[2], 0);
    chk("st_rd3", rec_rd[3], 0);
    chk("st_a2", rec_a[2], 1);
    chk("st_a3", rec_a[3], 1);
    chk("st_rd4", rec_rd[4], 1);
    chk("st_a4", rec_a[4], 1);
    chk("st_done_at", done_at, 48);
    chk("st_done_n", done_n, 1);

    // 3x3x3 with c_ready low for the first 5 WRITE cycles
    run(1, -1, -1, 5, 9, 60);
    for (int c = 5; c <= 10; c++) begin
      chk($sformatf("bp%0d_cv", c), rec_cv[c], 1);
      chk($sformatf("bp%0d_ca", c), rec_ca[c], 0);
    end
    chk("bp11_cv", rec_cv[11], 0);
    chk("bp11_rd", rec_rd[11], 1);
    chk("bp11_a", rec_a[11], 0);
    chk("bp11_b", rec_b[11], 1);
    chk("bp_done_at", done_at, 51);

    // 2x3x2 accumulator strobes: element e spans cycles 5e+1..5e+5
    run(2, -1, -1, -1, -1, 30);
    for (int e = 0; e < 4; e++) begin
      for (int p = 0; p < 5; p++) begin
        chk($sformatf("acc_e%0d_en%0d", e, p), rec_en[5*e+1+p],
            (p >= 1 && p <= 3) ? 1 : 0);
        chk($sformatf("acc_e%0d_clr%0d", e, p), rec_clr[5*e+1+p],
            (p == 1) ? 1 : 0);
      end
      chk($sformatf("acc_e%0d_ca", e), rec_ca[5*e+5], e);
    end
    chk("acc_b16", rec_b[16], 1);
    chk("acc_b17", rec_b[17], 3);
    chk("acc_b18", rec_b[18], 5);
    chk("acc_done_at", done_at, 21);

    // 1x1x1
    run(3, -1, -1, -1, -1, 8);
    chk("one_rd1", rec_rd[1], 1);
    chk("one_rd2", rec_rd[2], 0);
    chk("one_clr2", rec_clr[2], 1);
    chk("one_en2", rec_en[2], 1);
    chk("one_cv3", rec_cv[3], 1);
    chk("one_done_at", done_at, 4);
    chk("one_done_n", done_n, 1);

    // Asynchronous reset in the middle of element (1,0) on 2x2x2
    start_s[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      @(negedge clock);
      start_s[0] = 1'b0;
    end
    #1;
    chk("ar_a_pre", int'(a_o[0]), 3);
    chk("ar_b_pre", int'(b_o[0]), 2);
    nreset_s[0] = 1'b0;
    #1;
    chk("ar_busy", int'(busy_o[0]), 0);
    chk("ar_done", int'(done_o[0]), 0);
    chk("ar_rd", int'(rd_o[0]), 0);
    chk("ar_a", int'(a_o[0]), 0);
    chk("ar_b", int'(b_o[0]), 0);
    chk("ar_clr", int'(clr_o[0]), 0);
    chk("ar_en", int'(en_o[0]), 0);
    chk("ar_cv", int'(cv_o[0]), 0);
    chk("ar_ca", int'(ca_o[0]), 0);
    @(negedge clock);
    nreset_s[0] = 1'b1;
    start_s[0]  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_s[0] = 1'b0;
    #1;
    chk("ar_re_busy", int'(busy_o[0]), 1);
    chk("ar_re_rd", int'(rd_o[0]), 1);
    chk("ar_re_a", int'(a_o[0]), 0);
    chk("ar_re_b", int'(b_o[0]), 0);
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("ar_re_a1", int'(a_o[0]), 1);
    chk("ar_re_b1", int'(b_o[0]), 2);
    repeat (20) @(negedge clock);
    #1;
    chk("ar_idle", int'(busy_o[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
